game_round_ctrl: RTL and testbench
==================================

// Module: game_round_ctrl
// PURPOSE
//  Parametrised multi-round game engine for the binary encryption game. Sequences NUM_ROUNDS rounds:
//  - requests a random target, then arms a BCD countdown timer;
//  - judges the player's guess against the target and keeps a saturating BCD score.
//  Sits between access control/button shapers (start, guess, abort pulses) and the RNG, SSD router and LED logic.
// PARAMETERS
//  DATA_W        4           width of target and guess values
//  NUM_ROUNDS    8           rounds per session (>=1)
//  TIME_DIGITS   2           BCD digits of countdown timer
//  SCORE_DIGITS  2           BCD digits of score
//  TICKS_PER_SEC 50_000_000  clk cycles per timer decrement (>=2)
//  START_TIME    8'h30       BCD reload value of timer per round (width 4*TIME_DIGITS, non-zero)
// PORTS
//  clk          in   1               system clock, rising edge
//  rst          in   1               asynchronous reset, active-low
//  start        in   1               one-cycle pulse; starts session from IDLE or DONE
//  abort        in   1               one-cycle pulse; returns to IDLE from any state
//  target_in    in   DATA_W          RNG value, sampled in ARM
//  guess_valid  in   1               one-cycle pulse: guess_in is valid
//  guess_in     in   DATA_W          player guess
//  rng_load     out  1               one-cycle request to RNG (in LOAD)
//  busy         out  1               high in LOAD/ARM/PLAY/RESULT
//  done         out  1               high in DONE
//  round_idx    out  $clog2(NUM_ROUNDS+1)  current round, 0-based
//  time_bcd     out  4*TIME_DIGITS   remaining time, BCD
//  score_bcd    out  4*SCORE_DIGITS  score, BCD
//  hit, miss    out  1               one-cycle verdict pulses (in RESULT entry cycle)
//  timeout      out  1               one-cycle pulse when timer expires
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; score, time, round_idx, prescaler and target_q cleared.
//  FSM IDLE -> LOAD on start; clears score and round_idx.
//    LOAD   rng_load=1 for one cycle -> ARM.
//    ARM    target_q<=target_in; time<=START_TIME; prescaler<=0 -> PLAY.
//    PLAY   prescaler counts 0..TICKS_PER_SEC-1; at the wrap, time decrements by 1 in BCD (borrow across digits).
//           Decrement 1->0: timeout=1 and miss=1 that cycle -> RESULT.
//           guess_valid: if guess_in==target_q then hit=1 and score+1, else miss=1 -> RESULT.
//           guess_valid and expiry in the same cycle: the guess wins; no timeout.
//    RESULT one cycle; ignores guess_valid; round_idx+1.
//           If round_idx was NUM_ROUNDS-1 -> DONE, else -> LOAD.
//    DONE   done=1 held; score and time frozen; start -> LOAD, clearing score and round_idx.
//  Rules outside the FSM transitions:
//  - abort: highest priority in every state -> IDLE next cycle; score retained, time cleared, no verdict pulse.
//  - start outside IDLE/DONE is ignored.
//  - Score increments saturate at all-9s (99 for 2 digits); the saturated value holds.
//  - Guesses are ignored outside PLAY. Latency from guess pulse to hit/miss: 1 cycle (registered).
//  - Prescaler and time hold in every state except PLAY.
// CONFIGURATION
//  PENALTY_EN defined:
//  - every miss (wrong guess or timeout) decrements score by 1 in BCD;
//  - the decrement saturates at 0;
//  - a hit still increments.
//  PENALTY_EN undefined: a miss leaves score unchanged.
// STRUCTURE
//  Package game_pkg:
//  - state encoding (IDLE, LOAD, ARM, PLAY, RESULT, DONE);
//  - BCD digit width constant (4) and BCD_MAX (4'd9).
//  Sub-module bcd_counter #(DIGITS):
//  - load, inc, dec, clr;
//  - saturates at all-9s and at 0;
//  - zero flag.
//  Instantiated twice: timer (dec only) and score.
//  The FSM and prescaler live in game_round_ctrl.
// TESTING (TICKS_PER_SEC=4, START_TIME=8'h03, NUM_ROUNDS=2 unless noted)
//  1 Reset with rst=0 mid-PLAY -> all outputs 0 immediately; state IDLE after release.
//  2 start; target_in=4'h5; guess 5 in round 0 -> rng_load one cycle, hit, score 01, round_idx 1.
//    Then guess 3 in round 1 -> miss, score 01, done=1.
//  3 No guess -> time 03->02->01->00 every 4 cycles; timeout+miss on the 00 cycle; next round LOAD.
//  4 Guess pulse on the same cycle the timer hits 00, correct guess -> hit=1, timeout=0.
//  5 abort in PLAY with score 01 -> IDLE next cycle; score 01, time 00, busy 0.
//    A second start -> score 00.
//  6 SCORE_DIGITS=1, NUM_ROUNDS=12, all hits -> score saturates at 9.
//    With PENALTY_EN: score 00 and a miss -> score stays 00.

Source files
------------

// File: rtl/game_round_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the binary-encryption game round controller:
//   - state_t  : round FSM encoding
//   - BCD_W    : bits per BCD digit
//   - BCD_MAX  : largest legal BCD digit value
// -----------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_ARM    = 3'd2,
    ST_PLAY   = 3'd3,
    ST_RESULT = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage : game_pkg

// File: rtl/game_round_ctrl_if.sv
// -----------------------------------------------------------------------------
// game_round_ctrl_if
// Bundles the control pulses, RNG/guess data and status outputs of the round
// controller.
//   master : the side that issues start/abort/guesses and supplies target_in
//   slave  : the round controller itself
// Signals:
//   start, abort, guess_valid (pulses), target_in, guess_in  -> controller
//   rng_load, busy, done, round_idx, time_bcd, score_bcd,
//   hit, miss, timeout                                        <- controller
// -----------------------------------------------------------------------------
interface game_round_ctrl_if #(
  parameter int DATA_W       = 4,
  parameter int NUM_ROUNDS   = 8,
  parameter int TIME_DIGITS  = 2,
  parameter int SCORE_DIGITS = 2
);

  localparam int ROUND_W = $clog2(NUM_ROUNDS + 1);

  logic                      start;
  logic                      abort;
  logic [DATA_W-1:0]         target_in;
  logic                      guess_valid;
  logic [DATA_W-1:0]         guess_in;

  logic                      rng_load;
  logic                      busy;
  logic                      done;
  logic [ROUND_W-1:0]        round_idx;
  logic [4*TIME_DIGITS-1:0]  time_bcd;
  logic [4*SCORE_DIGITS-1:0] score_bcd;
  logic                      hit;
  logic                      miss;
  logic                      timeout;

  modport master (
    output start, abort, target_in, guess_valid, guess_in,
    input  rng_load, busy, done, round_idx, time_bcd, score_bcd,
           hit, miss, timeout
  );

  modport slave (
    input  start, abort, target_in, guess_valid, guess_in,
    output rng_load, busy, done, round_idx, time_bcd, score_bcd,
           hit, miss, timeout
  );

endinterface : game_round_ctrl_if

// File: rtl/game_round_ctrl_bcd_counter.sv
// -----------------------------------------------------------------------------
// bcd_counter
// Multi-digit BCD up/down counter that saturates at all-9s and at zero.
// Priority: clear > load > increment > decrement.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   i_clr           synchronous clear to 0
//   i_load          load i_load_val
//   i_inc / i_dec   +1 / -1 in BCD (held at the saturation limits)
//   o_value         current BCD value
//   o_zero          value is zero
// -----------------------------------------------------------------------------
module bcd_counter
  import game_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_clr,
  input  logic                      i_load,
  input  logic [BCD_W*DIGITS-1:0]   i_load_val,
  input  logic                      i_inc,
  input  logic                      i_dec,
  output logic [BCD_W*DIGITS-1:0]   o_value,
  output logic                      o_zero
);

  localparam int W = BCD_W * DIGITS;

  logic [W-1:0] r_value;
  logic [W-1:0] w_inc_val;
  logic [W-1:0] w_dec_val;
  logic         w_is_max;
  logic         w_is_zero;

  assign w_is_max  = (r_value == {DIGITS{BCD_MAX}});
  assign w_is_zero = (r_value == '0);

  // Ripple the carry from the least significant digit upward.
  // NOTE: combinational blocks use blocking '=' so the carry/borrow chain
  // updates in loop order; clocked state below uses non-blocking '<='.
  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin : inc_path
    logic carry;
    w_inc_val = r_value;
    carry     = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (carry) begin
        if (r_value[BCD_W*d +: BCD_W] == BCD_MAX) begin
          w_inc_val[BCD_W*d +: BCD_W] = 4'd0;
        end else begin
          w_inc_val[BCD_W*d +: BCD_W] = r_value[BCD_W*d +: BCD_W] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_comb begin : dec_path
    logic borrow;
    w_dec_val = r_value;
    borrow    = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (borrow) begin
        if (r_value[BCD_W*d +: BCD_W] == 4'd0) begin
          w_dec_val[BCD_W*d +: BCD_W] = BCD_MAX;
        end else begin
          w_dec_val[BCD_W*d +: BCD_W] = r_value[BCD_W*d +: BCD_W] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_value <= '0;
    end else if (i_clr) begin
      r_value <= '0;
    end else if (i_load) begin
      r_value <= i_load_val;
    end else if (i_inc && !w_is_max) begin
      r_value <= w_inc_val;
    end else if (i_dec && !w_is_zero) begin
      r_value <= w_dec_val;
    end
  end

  assign o_value = r_value;
  assign o_zero  = w_is_zero;

endmodule : bcd_counter

// File: rtl/game_round_ctrl.sv
// -----------------------------------------------------------------------------
// game_round_ctrl
// Multi-round engine for the binary encryption game. Per round it requests a
// random target, arms a BCD countdown, then judges one guess (or the timer
// expiry) and updates a saturating BCD score. After NUM_ROUNDS rounds it
// parks in DONE until the next start.
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous reset, active-low
//   bus   game_round_ctrl_if.slave
//         in : start, abort, target_in, guess_valid, guess_in
//         out: rng_load, busy, done, round_idx, time_bcd, score_bcd,
//              hit, miss, timeout
// Build option:
//   PENALTY_EN  when defined, every miss (wrong guess or timeout) takes one
//               point off the score, saturating at zero.
// -----------------------------------------------------------------------------
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int                          DATA_W        = 4,
  parameter int                          NUM_ROUNDS    = 8,
  parameter int                          TIME_DIGITS   = 2,
  parameter int                          SCORE_DIGITS  = 2,
  parameter int                          TICKS_PER_SEC = 50_000_000,
  parameter logic [BCD_W*TIME_DIGITS-1:0] START_TIME   = 8'h30
) (
  input  logic             clk,
  input  logic             rst,
  game_round_ctrl_if.slave bus
);

  localparam int ROUND_W = $clog2(NUM_ROUNDS + 1);
  localparam int PRESC_W = $clog2(TICKS_PER_SEC);
  localparam int TIME_W  = BCD_W * TIME_DIGITS;
  localparam int SCORE_W = BCD_W * SCORE_DIGITS;

`ifdef PENALTY_EN
  localparam bit PENALTY = 1'b1;
`else
  localparam bit PENALTY = 1'b0;
`endif

  state_t              r_state;
  state_t              w_next_state;

  logic [PRESC_W-1:0]  r_presc;
  logic [ROUND_W-1:0]  r_round_idx;
  logic [DATA_W-1:0]   r_target_q;
  logic                r_hit;
  logic                r_miss;
  logic                r_timeout;

  logic [TIME_W-1:0]   w_time_bcd;
  logic [SCORE_W-1:0]  w_score_bcd;
  logic                w_time_zero;
  logic                w_score_zero;

  logic                w_in_play;
  logic                w_wrap;
  logic                w_expire;
  logic                w_match;
  logic                w_session_start;
  logic                w_hit_set;
  logic                w_miss_set;
  logic                w_timeout_set;
  logic                w_time_dec;
  logic                w_score_dec;
  logic                w_last_round;

  logic                w_rng_load;
  logic                w_busy;
  logic                w_done;

  // ---------------------------------------------------------------------------
  // Qualifiers. Abort overrides everything, so every action is gated by it.
  // ---------------------------------------------------------------------------
  assign w_in_play       = (r_state == ST_PLAY) && !bus.abort;
  assign w_wrap          = (r_presc == PRESC_W'(TICKS_PER_SEC - 1));
  // Expiry is the tick that takes the timer from 1 to 0.
  assign w_expire        = w_wrap && (w_time_bcd == TIME_W'(1));
  assign w_match         = (bus.guess_in == r_target_q);
  assign w_session_start = bus.start && !bus.abort &&
                           ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last_round    = (r_round_idx == ROUND_W'(NUM_ROUNDS - 1));

  // A guess in the expiry cycle takes precedence over the timeout.
  assign w_hit_set     = w_in_play && bus.guess_valid && w_match;
  assign w_miss_set    = w_in_play && ((bus.guess_valid && !w_match) ||
                                       (!bus.guess_valid && w_expire));
  assign w_timeout_set = w_in_play && !bus.guess_valid && w_expire;

  assign w_time_dec    = w_in_play && w_wrap && !w_time_zero;
  assign w_score_dec   = PENALTY && w_miss_set && !w_score_zero;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    if (bus.abort) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (bus.start) w_next_state = ST_LOAD;
        ST_LOAD:   w_next_state = ST_ARM;
        ST_ARM:    w_next_state = ST_PLAY;
        ST_PLAY:   if (bus.guess_valid || w_expire) w_next_state = ST_RESULT;
        ST_RESULT: w_next_state = w_last_round ? ST_DONE : ST_LOAD;
        ST_DONE:   if (bus.start) w_next_state = ST_LOAD;
        default:   w_next_state = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_rng_load = 1'b0;
    w_busy     = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      ST_LOAD:   begin w_rng_load = 1'b1; w_busy = 1'b1; end
      ST_ARM,
      ST_PLAY,
      ST_RESULT: w_busy = 1'b1;
      ST_DONE:   w_done = 1'b1;
      default:   ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Prescaler: runs only in PLAY, restarts from 0 when a round is armed.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
    end else if ((r_state == ST_ARM) && !bus.abort) begin
      r_presc <= '0;
    end else if (w_in_play) begin
      r_presc <= w_wrap ? '0 : r_presc + PRESC_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Round index, captured target and registered verdict pulses.
  // The verdicts are registered on the PLAY->RESULT edge, so they are high
  // exactly for the single RESULT cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_round_idx <= '0;
      r_target_q  <= '0;
      r_hit       <= 1'b0;
      r_miss      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      if (w_session_start) begin
        r_round_idx <= '0;
      end else if ((r_state == ST_RESULT) && !bus.abort) begin
        r_round_idx <= r_round_idx + ROUND_W'(1);
      end
      if ((r_state == ST_ARM) && !bus.abort) begin
        r_target_q <= bus.target_in;
      end
      r_hit     <= w_hit_set;
      r_miss    <= w_miss_set;
      r_timeout <= w_timeout_set;
    end
  end

  // ---------------------------------------------------------------------------
  // Countdown timer and score
  // ---------------------------------------------------------------------------
  bcd_counter #(.DIGITS(TIME_DIGITS)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (bus.abort),
    .i_load     (r_state == ST_ARM),
    .i_load_val (START_TIME),
    .i_inc      (1'b0),
    .i_dec      (w_time_dec),
    .o_value    (w_time_bcd),
    .o_zero     (w_time_zero)
  );

  bcd_counter #(.DIGITS(SCORE_DIGITS)) u_score (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_session_start),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_inc      (w_hit_set),
    .i_dec      (w_score_dec),
    .o_value    (w_score_bcd),
    .o_zero     (w_score_zero)
  );

  // ---------------------------------------------------------------------------
  // Interface outputs
  // ---------------------------------------------------------------------------
  assign bus.rng_load  = w_rng_load;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.round_idx = r_round_idx;
  assign bus.time_bcd  = w_time_bcd;
  assign bus.score_bcd = w_score_bcd;
  assign bus.hit       = r_hit;
  assign bus.miss      = r_miss;
  assign bus.timeout   = r_timeout;

endmodule : game_round_ctrl

// File: tb/tb_game_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_round_ctrl
// Directed bench for game_round_ctrl. Two instances share clk/rst:
//   dut_a : NUM_ROUNDS=2, SCORE_DIGITS=2, TICKS_PER_SEC=4, START_TIME=8'h03
//   dut_b : NUM_ROUNDS=12, SCORE_DIGITS=1, same timing
// Expected values are hand-derived; PENALTY_EN selects the miss expectation.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_game_round_ctrl;

`ifdef PENALTY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  game_round_ctrl_if #(.DATA_W(4), .NUM_ROUNDS(2),  .TIME_DIGITS(2), .SCORE_DIGITS(2)) a_if ();
  game_round_ctrl_if #(.DATA_W(4), .NUM_ROUNDS(12), .TIME_DIGITS(2), .SCORE_DIGITS(1)) b_if ();

  game_round_ctrl #(
    .DATA_W(4), .NUM_ROUNDS(2), .TIME_DIGITS(2), .SCORE_DIGITS(2),
    .TICKS_PER_SEC(4), .START_TIME(8'h03)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  game_round_ctrl #(
    .DATA_W(4), .NUM_ROUNDS(12), .TIME_DIGITS(2), .SCORE_DIGITS(1),
    .TICKS_PER_SEC(4), .START_TIME(8'h03)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges; return 1 ns after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    a_if.start = 0; a_if.abort = 0; a_if.target_in = 4'h5; a_if.guess_valid = 0; a_if.guess_in = 0;
    b_if.start = 0; b_if.abort = 0; b_if.target_in = 4'h7; b_if.guess_valid = 0; b_if.guess_in = 0;

    // ---------------- Reset state
    tick(2);
    rst = 1'b1;
    tick(1);
    check("rst_busy",  a_if.busy, 0);
    check("rst_done",  a_if.done, 0);
    check("rst_score", a_if.score_bcd, 0);
    check("rst_time",  a_if.time_bcd, 0);
    check("rst_round", a_if.round_idx, 0);

    // ---------------- Hit in round 0, miss in round 1
    a_if.start = 1; tick(1); a_if.start = 0;               // LOAD
    check("t2_rng_load", a_if.rng_load, 1);
    check("t2_busy", a_if.busy, 1);
    tick(1);                                                 // ARM
    check("t2_rng_load_1cyc", a_if.rng_load, 0);
    tick(1);                                                 // PLAY
    check("t2_time_armed", a_if.time_bcd, 8'h03);
    a_if.guess_valid = 1; a_if.guess_in = 4'h5; tick(1);     // RESULT
    a_if.guess_valid = 0;
    check("t2_hit", a_if.hit, 1);
    check("t2_no_miss", a_if.miss, 0);
    check("t2_score1", a_if.score_bcd, 8'h01);
    tick(1);                                                 // LOAD
    check("t2_round1", a_if.round_idx, 1);
    check("t2_hit_pulse", a_if.hit, 0);
    tick(2);                                                 // PLAY
    a_if.guess_valid = 1; a_if.guess_in = 4'h3; tick(1);     // RESULT
    a_if.guess_valid = 0;
    check("t2_miss", a_if.miss, 1);
    check("t2_miss_hit", a_if.hit, 0);
    check("t2_miss_score", a_if.score_bcd, PEN ? 8'h00 : 8'h01);
    tick(1);                                                 // DONE
    check("t2_done", a_if.done, 1);
    check("t2_done_busy", a_if.busy, 0);
    check("t2_done_round", a_if.round_idx, 2);
    tick(3);
    check("t2_done_held", a_if.done, 1);
    check("t2_done_score", a_if.score_bcd, PEN ? 8'h00 : 8'h01);

    // ---------------- Timer countdown and timeout
    a_if.start = 1; tick(1); a_if.start = 0;               // LOAD
    check("t3_score_clr", a_if.score_bcd, 0);
    check("t3_round_clr", a_if.round_idx, 0);
    tick(2);                                                 // PLAY cycle 0
    tick(3);
    check("t3_time03", a_if.time_bcd, 8'h03);
    tick(1);
    check("t3_time02", a_if.time_bcd, 8'h02);
    tick(4);
    check("t3_time01", a_if.time_bcd, 8'h01);
    tick(3);
    check("t3_no_timeout", a_if.timeout, 0);
    tick(1);                                                 // RESULT
    check("t3_time00", a_if.time_bcd, 8'h00);
    check("t3_timeout", a_if.timeout, 1);
    check("t3_to_miss", a_if.miss, 1);
    check("t3_to_hit", a_if.hit, 0);
    tick(1);                                                 // LOAD
    check("t3_next_load", a_if.rng_load, 1);
    check("t3_to_pulse", a_if.timeout, 0);

    // ---------------- Guess in the expiry cycle
    tick(2);                                                 // PLAY cycle 0
    tick(11);                                                // cycle 11
    check("t4_time01", a_if.time_bcd, 8'h01);
    a_if.guess_valid = 1; a_if.guess_in = 4'h5; tick(1);
    a_if.guess_valid = 0;
    check("t4_hit", a_if.hit, 1);
    check("t4_timeout", a_if.timeout, 0);
    check("t4_miss", a_if.miss, 0);
    check("t4_score", a_if.score_bcd, 8'h01);
    tick(1);
    check("t4_done", a_if.done, 1);

    // ---------------- Abort in PLAY
    a_if.start = 1; tick(1); a_if.start = 0;               // LOAD
    tick(2);                                                 // PLAY
    a_if.guess_valid = 1; a_if.guess_in = 4'h5; tick(1);     // RESULT
    a_if.guess_valid = 0;
    check("t5_score1", a_if.score_bcd, 8'h01);
    tick(3);                                                 // PLAY round 1
    tick(2);
    a_if.abort = 1; a_if.guess_valid = 1; a_if.guess_in = 4'h5; tick(1);
    a_if.abort = 0; a_if.guess_valid = 0;
    check("t5_busy", a_if.busy, 0);
    check("t5_score_kept", a_if.score_bcd, 8'h01);
    check("t5_time_clr", a_if.time_bcd, 8'h00);
    check("t5_no_hit", a_if.hit, 0);
    tick(1);
    check("t5_idle", a_if.busy, 0);
    a_if.start = 1; tick(1); a_if.start = 0;               // LOAD
    check("t5_restart_score", a_if.score_bcd, 8'h00);
    check("t5_restart_busy", a_if.busy, 1);

    // ---------------- Start ignored mid-round, then reset mid-PLAY
    tick(2);                                                 // PLAY
    a_if.guess_valid = 1; a_if.guess_in = 4'h5; tick(1);     // RESULT
    a_if.guess_valid = 0;
    tick(3);                                                 // PLAY round 1
    a_if.start = 1; tick(1); a_if.start = 0;
    check("t1_start_ign_load", a_if.rng_load, 0);
    check("t1_start_ign_round", a_if.round_idx, 1);
    check("t1_start_ign_time", a_if.time_bcd, 8'h03);
    rst = 1'b0;
    #2;
    check("t1_rst_busy", a_if.busy, 0);
    check("t1_rst_score", a_if.score_bcd, 0);
    check("t1_rst_time", a_if.time_bcd, 0);
    check("t1_rst_round", a_if.round_idx, 0);
    tick(2);
    rst = 1'b1;
    tick(1);
    check("t1_idle_busy", a_if.busy, 0);
    check("t1_idle_done", a_if.done, 0);

    // ---------------- One-digit score saturates at 9
    b_if.start = 1; tick(1); b_if.start = 0;               // LOAD
    for (int r = 0; r < 12; r++) begin
      tick(2);                                               // PLAY
      b_if.guess_valid = 1; b_if.guess_in = 4'h7; tick(1);   // RESULT
      b_if.guess_valid = 0;
      check($sformatf("t6_score_r%0d", r), b_if.score_bcd, (r + 1 > 9) ? 9 : r + 1);
      tick(1);
    end
    check("t6_done", b_if.done, 1);
    check("t6_round", b_if.round_idx, 12);
    check("t6_sat", b_if.score_bcd, 4'h9);

    // Miss with score 0 stays at 0
    b_if.start = 1; tick(1); b_if.start = 0;
    check("t6_clr", b_if.score_bcd, 0);
    tick(2);
    b_if.guess_valid = 1; b_if.guess_in = 4'h3; tick(1);
    b_if.guess_valid = 0;
    check("t6_miss", b_if.miss, 1);
    check("t6_miss_floor", b_if.score_bcd, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_game_round_ctrl
